// File: rtl/add_chain_if.sv
// Bus-side command, operand-stream and result-stream signals of add_chain_ctrl.
// master: the bus agent issuing commands and operands and consuming results.
// slave:  the sequencer.
interface add_chain_if #(
    parameter int unsigned WORDS_W = 2
);
    localparam int unsigned DW = 16;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [WORDS_W-1:0] cmd_words;
    logic               cmd_sub;

    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_a;
    logic [DW-1:0]      in_b;

    logic               res_valid;
    logic               res_ready;
    logic [DW-1:0]      res_data;
    logic               res_last;
    logic               res_carry;

    modport master (
        output cmd_valid, cmd_words, cmd_sub,
        output in_valid, in_a, in_b,
        output res_ready,
        input  cmd_ready, in_ready,
        input  res_valid, res_data, res_last, res_carry
    );

    modport slave (
        input  cmd_valid, cmd_words, cmd_sub,
        input  in_valid, in_a, in_b,
        input  res_ready,
        output cmd_ready, in_ready,
        output res_valid, res_data, res_last, res_carry
    );
endinterface

// File: rtl/add_chain_ctrl.sv
// Sequencer for the 16-bit operand/adder/result datapath: runs a 1..2^WORDS_W
// word addition LS word first, chaining the carry between words.
// Optional subtraction is enabled by defining ADD_CHAIN_SUB_EN.
module add_chain_ctrl #(
    parameter int unsigned WORDS_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    add_chain_if.slave  bus,
    output logic        busy,
    output logic [15:0] dp_d_a,
    output logic [15:0] dp_d_b,
    output logic        dp_en_a,
    output logic        dp_en_b,
    output logic        dp_en_result,
    output logic        dp_cin,
    input  logic [15:0] dp_result,
    input  logic        dp_cout
);
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ADD   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WORDS_W-1:0] words_q, words_d;
    logic [WORDS_W-1:0] idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q;
    logic               init_carry;
    logic               last_word;

`ifdef ADD_CHAIN_SUB_EN
    // Subtract mode is latched with the command; A-B = A + ~B + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (state_q == IDLE && bus.cmd_valid) begin
            sub_q <= bus.cmd_sub;
        end
    end

    assign init_carry = bus.cmd_sub;
`else
    logic unused_cmd_sub;

    assign sub_q          = 1'b0;
    assign init_carry     = 1'b0;
    assign unused_cmd_sub = bus.cmd_sub;
`endif

    // Operand words pass straight through; B is inverted when subtracting.
    assign dp_d_a = bus.in_a;
    assign dp_d_b = sub_q ? ~bus.in_b : bus.in_b;

    assign bus.res_data = dp_result;
    assign busy         = (state_q != IDLE);
    assign last_word    = (idx_q == words_q);

    // State and chain-context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            words_q <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    // Next-state and state-decoded handshake/datapath controls.
    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        idx_d         = idx_q;
        carry_d       = carry_q;
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
        bus.res_carry = 1'b0;
        dp_en_a       = 1'b0;
        dp_en_b       = 1'b0;
        dp_en_result  = 1'b0;
        dp_cin        = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    words_d = bus.cmd_words;
                    idx_d   = '0;
                    carry_d = init_carry;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    dp_en_a = 1'b1;
                    dp_en_b = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                dp_cin       = carry_q;
                dp_en_result = 1'b1;
                carry_d      = dp_cout;
                state_d      = DRAIN;
            end
            DRAIN: begin
                bus.res_valid = 1'b1;
                bus.res_carry = carry_q;
                bus.res_last  = last_word;
                if (bus.res_ready) begin
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + WORDS_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Width bookkeeping for the fixed 16-bit datapath word.
    if (DW != 16) begin : g_bad_width
        $error("add_chain_ctrl supports only a 16-bit datapath");
    end
endmodule

// File: tb/tb_add_chain_ctrl.sv
// Directed bench for add_chain_ctrl with a behavioural 16-bit datapath.
module tb_add_chain_ctrl;
    localparam int unsigned WORDS_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] dp_d_a, dp_d_b, dp_result;
    logic        dp_en_a, dp_en_b, dp_en_result, dp_cin, dp_cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    add_chain_if #(.WORDS_W(WORDS_W)) bus ();

    add_chain_ctrl #(.WORDS_W(WORDS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .dp_d_a       (dp_d_a),
        .dp_d_b       (dp_d_b),
        .dp_en_a      (dp_en_a),
        .dp_en_b      (dp_en_b),
        .dp_en_result (dp_en_result),
        .dp_cin       (dp_cin),
        .dp_result    (dp_result),
        .dp_cout      (dp_cout)
    );

    // Datapath: operand registers, combinational adder, result register.
    logic [15:0] ra, rb, rres;
    logic [16:0] sum17;
    assign sum17     = {1'b0, ra} + {1'b0, rb} + {16'd0, dp_cin};
    assign dp_cout   = sum17[16];
    assign dp_result = rres;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rres <= '0;
        end else begin
            if (dp_en_a)      ra   <= dp_d_a;
            if (dp_en_b)      rb   <= dp_d_b;
            if (dp_en_result) rres <= sum17[15:0];
        end
    end

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_words = '0;
        bus.cmd_sub   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
    endtask

    // Issue one command from a negedge; returns at the negedge after acceptance.
    task automatic issue_cmd(input logic [1:0] words, input logic sub, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_words = words;
        bus.cmd_sub   = sub;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Stream one operand pair and consume its result word.
    // lat counts cycles from the in-handshake cycle (0) to the first res_valid cycle.
    task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] data, output logic carry,
                             output logic last, output logic cin,
                             output int lat, output bit ok);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        ok   = 1'b0;
        lat  = 0;
        data = 'x;
        carry = 1'bx;
        last = 1'bx;
        cin  = 1'bx;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        cin = dp_cin;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!ok) return;
        data  = bus.res_data;
        carry = bus.res_carry;
        last  = bus.res_last;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        logic [9:0] obs;
        issue_cmd(2'd1, 1'b0, ok);
        tests++;
        if (ok !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy: ok=%0b busy=%0b required ok=1 busy=1", ok, busy);
        end
        rst = 1'b1;
        #1;
        obs = {bus.cmd_ready, busy, bus.in_ready, bus.res_valid, bus.res_last,
               bus.res_carry, dp_en_a, dp_en_b, dp_en_result, dp_cin};
        tests++;
        if (obs !== 10'b10_0000_0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b required %b", obs, 10'b10_0000_0000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: cmd_ready=%0b busy=%0b required 1/0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_single_word();
        bit ok;
        logic [15:0] d;
        logic c, l, ci;
        int lat;
        issue_cmd(2'd0, 1'b0, ok);
        send_word(16'h1234, 16'h0001, d, c, l, ci, lat, ok);
        tests++;
        if (ok !== 1'b1 || d !== 16'h1235 || c !== 1'b0 || l !== 1'b1 || ci !== 1'b0) begin
            fails++;
            $display("FAIL single_word: ok=%0b data=%h carry=%0b last=%0b cin=%0b required 1 1235 0 1 0",
                     ok, d, c, l, ci);
        end
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL single_latency: got %0d required 2", lat);
        end
    endtask

    task automatic test_carry_chain_32();
        bit ok;
        logic [15:0] d;
        logic c, l, ci;
        int lat;
        issue_cmd(2'd1, 1'b0, ok);
        send_word(16'hFFFF, 16'h0001, d, c, l, ci, lat, ok);
        tests++;
        if (ok !== 1'b1 || d !== 16'h0000 || c !== 1'b1 || l !== 1'b0 || ci !== 1'b0) begin
            fails++;
            $display("FAIL chain32_w0: ok=%0b data=%h carry=%0b last=%0b cin=%0b required 1 0000 1 0 0",
                     ok, d, c, l, ci);
        end
        send_word(16'h0000, 16'h0000, d, c, l, ci, lat, ok);
        tests++;
        if (ok !== 1'b1 || d !== 16'h0001 || c !== 1'b0 || l !== 1'b1 || ci !== 1'b1) begin
            fails++;
            $display("FAIL chain32_w1: ok=%0b data=%h carry=%0b last=%0b cin=%0b required 1 0001 0 1 1",
                     ok, d, c, l, ci);
        end
    endtask

    task automatic test_overflow_64();
        bit ok;
        logic [15:0] d;
        logic c, l, ci;
        int lat;
        issue_cmd(2'd3, 1'b0, ok);
        for (int i = 0; i < 4; i++) begin
            send_word(16'hFFFF, (i == 0) ? 16'h0001 : 16'h0000, d, c, l, ci, lat, ok);
            tests++;
            if (ok !== 1'b1 || d !== 16'h0000 || c !== 1'b1 || l !== (i == 3) || ci !== (i != 0)) begin
                fails++;
                $display("FAIL overflow64_w%0d: ok=%0b data=%h carry=%0b last=%0b cin=%0b required 1 0000 1 %0b %0b",
                         i, ok, d, c, l, ci, (i == 3), (i != 0));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        issue_cmd(2'd0, 1'b0, ok);
        bus.in_a     = 16'h00AA;
        bus.in_b     = 16'h0055;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL bp_res_valid_timeout: res_valid never rose");
        end
        // in_valid stays high throughout: it must not be taken outside FETCH.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h00FF ||
                bus.in_ready !== 1'b0 || dp_en_a !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: valid=%0b data=%h in_ready=%0b en_a=%0b required 1 00ff 0 0",
                         i, bus.res_valid, bus.res_data, bus.in_ready, dp_en_a);
            end
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        tests++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: cmd_ready=%0b res_valid=%0b required 1 0", bus.cmd_ready, bus.res_valid);
        end
    endtask

    task automatic test_reset_mid_chain();
        bit ok;
        logic [15:0] d;
        logic c, l, ci;
        int lat;
        issue_cmd(2'd2, 1'b0, ok);
        send_word(16'hFFFF, 16'h0001, d, c, l, ci, lat, ok);
        bus.in_a     = 16'h0000;
        bus.in_b     = 16'h0000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++;
        if (dp_cin !== 1'b1 || dp_en_result !== 1'b1) begin
            fails++;
            $display("FAIL midreset_add: cin=%0b en_result=%0b required 1 1", dp_cin, dp_en_result);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || dp_cin !== 1'b0 || dp_en_result !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: busy=%0b cmd_ready=%0b cin=%0b en_result=%0b required 0 1 0 0",
                     busy, bus.cmd_ready, dp_cin, dp_en_result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_cmd(2'd0, 1'b0, ok);
        send_word(16'h0005, 16'h0007, d, c, l, ci, lat, ok);
        tests++;
        if (ok !== 1'b1 || d !== 16'h000C || c !== 1'b0 || l !== 1'b1 || ci !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after: ok=%0b data=%h carry=%0b last=%0b cin=%0b required 1 000c 0 1 0",
                     ok, d, c, l, ci);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bus.in_a      = 16'h0001;
        bus.in_b      = 16'h0001;
        bus.in_valid  = 1'b1;
        bus.res_ready = 1'b1;
        bus.cmd_words = 2'd1;
        bus.cmd_valid = 1'b1;
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_start: cmd_ready=%0b required 1", bus.cmd_ready);
        end
        // cmd_valid held high through the command: it must be ignored while busy.
        @(negedge clk);
        cnt = 1;
        while (bus.cmd_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (cnt !== 7) begin
            fails++;
            $display("FAIL b2b_two_word_cycles: got %0d required 7", cnt);
        end
        bus.cmd_words = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_accept: busy=%0b required 1", busy);
        end
        cnt = 1;
        while (bus.cmd_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (cnt !== 4) begin
            fails++;
            $display("FAIL b2b_one_word_cycles: got %0d required 4", cnt);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_sub();
        bit ok;
        logic [15:0] d0, d1, e0, e1;
        logic c0, c1, l0, l1, ci, ec0, ec1;
        int lat;
`ifdef ADD_CHAIN_SUB_EN
        e0 = 16'hFFFF; ec0 = 1'b0;
        e1 = 16'h0000; ec1 = 1'b1;
`else
        e0 = 16'h0001; ec0 = 1'b0;
        e1 = 16'h0001; ec1 = 1'b0;
`endif
        issue_cmd(2'd1, 1'b1, ok);
        send_word(16'h0000, 16'h0001, d0, c0, l0, ci, lat, ok);
        send_word(16'h0001, 16'h0000, d1, c1, l1, ci, lat, ok);
        tests++;
        if (d0 !== e0 || c0 !== ec0 || l0 !== 1'b0) begin
            fails++;
            $display("FAIL sub_w0: data=%h carry=%0b last=%0b required %h %0b 0", d0, c0, l0, e0, ec0);
        end
        tests++;
        if (ok !== 1'b1 || d1 !== e1 || c1 !== ec1 || l1 !== 1'b1) begin
            fails++;
            $display("FAIL sub_w1: ok=%0b data=%h carry=%0b last=%0b required 1 %h %0b 1", ok, d1, c1, l1, e1, ec1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0 || dp_en_result !== 1'b0) begin
            fails++;
            $display("FAIL por_state: cmd_ready=%0b busy=%0b res_valid=%0b en_result=%0b required 1 0 0 0",
                     bus.cmd_ready, busy, bus.res_valid, dp_en_result);
        end
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_single_word();
        test_carry_chain_32();
        test_overflow_64();
        test_backpressure();
        test_reset_mid_chain();
        test_back_to_back();
        test_sub();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
